// File: rtl/cga_pkg.sv
// Shared types and constants for the CGA alphanumeric fetch path.
// The cursor feature of cga_text_fetch is enabled by defining CGA_CURSOR_EN.
package cga_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_CHAR,
    RD_ATTR,
    RD_FONT,
    READY
  } fetch_state_t;

  typedef struct packed {
    fetch_state_t state;
    logic [4:0]   blink_cnt;
  } fetch_dbg_t;

  localparam int BLINK_CHAR_BIT   = 4;
  localparam int BLINK_CURSOR_BIT = 3;
  localparam int CELL_W           = 8;

  // Colour of one pixel given its font bit, the cell attribute and the blink phase.
  function automatic logic [3:0] cell_pixel(input logic       on,
                                            input logic [7:0] attr,
                                            input logic       blink_en,
                                            input logic       blink_phase);
    logic       hide;
    logic [3:0] bg;
    hide = blink_en & attr[7] & blink_phase;
    bg   = blink_en ? {1'b0, attr[6:4]} : attr[7:4];
    return (on && !hide) ? attr[3:0] : bg;
  endfunction

endpackage

// File: rtl/cga_blink_timer.sv
// Frame counter used as the blink timebase; one step per vsync pulse, wraps at 32.
module cga_blink_timer
  import cga_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync_pulse,
  output logic [4:0] blink_cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
    end else if (vsync_pulse) begin
      blink_cnt <= blink_cnt + 5'd1;
    end
  end

endmodule

// File: rtl/cga_text_fetch.sv
// Per-cell char/attr/font fetch and RGBI pixel shifter for CGA text modes.
// Define CGA_CURSOR_EN to add the cursor_in port and the blinking block cursor.
module cga_text_fetch
  import cga_pkg::*;
#(
  parameter int AW  = 15,
  parameter int MAW = 14
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pix_ce,
  input  logic           char_start,
  input  logic           disp_en_in,
  input  logic [MAW-1:0] ma,
  input  logic [2:0]     ra,
  input  logic           vsync_pulse,
  input  logic           blink_en,
`ifdef CGA_CURSOR_EN
  input  logic           cursor_in,
`endif
  output logic [AW-1:0]  pixel_addr,
  output logic           pixel_read,
  input  logic [7:0]     pixel_data,
  output logic [10:0]    font_addr,
  input  logic [7:0]     font_data,
  output logic [3:0]     rgbi,
  output logic           disp_en_out,
  output logic           underrun,
  output fetch_dbg_t     dbg
);

  // VRAM read port: a cycle with pixel_read=1 presents pixel_addr, and the byte
  // appears on pixel_data during the following cycle. There is no back-pressure.
  fetch_state_t      state;
  logic [4:0]        blink_cnt;
  logic [2:0]        ra_q;
  logic [7:0]        char_q;
  logic [7:0]        attr_q;
  logic [7:0]        font_q;
  logic              fetch_de;
  logic [CELL_W-1:0] shreg;
  logic [7:0]        attr_out;
`ifdef CGA_CURSOR_EN
  logic              cursor_q;
`endif

  cga_blink_timer u_blink (
    .clk         (clk),
    .reset       (reset),
    .vsync_pulse (vsync_pulse),
    .blink_cnt   (blink_cnt)
  );

  // The char byte is on pixel_data only during RD_ATTR; bypass it so the font
  // ROM answer lands together with the attribute byte.
  assign font_addr = (state == RD_ATTR) ? {pixel_data, ra_q} : {char_q, ra_q};

  assign dbg = {state, blink_cnt};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pixel_addr  <= '0;
      pixel_read  <= 1'b0;
      ra_q        <= '0;
      char_q      <= '0;
      attr_q      <= '0;
      font_q      <= '0;
      fetch_de    <= 1'b0;
      shreg       <= '0;
      attr_out    <= '0;
      disp_en_out <= 1'b0;
      underrun    <= 1'b0;
      rgbi        <= '0;
`ifdef CGA_CURSOR_EN
      cursor_q    <= 1'b0;
`endif
    end else begin
      if (char_start) begin
        // Display the cell fetched during the previous cell; blank if it never completed.
        if (state == READY) begin
          shreg    <= font_q;
          attr_out <= attr_q;
`ifdef CGA_CURSOR_EN
          if (cursor_q && blink_cnt[BLINK_CURSOR_BIT]) begin
            shreg <= '1;
          end
`endif
        end else begin
          shreg    <= '0;
          attr_out <= '0;
        end
        disp_en_out <= fetch_de;
        fetch_de    <= disp_en_in;
`ifdef CGA_CURSOR_EN
        cursor_q    <= cursor_in;
`endif
        if (state inside {RD_CHAR, RD_ATTR, RD_FONT}) begin
          underrun <= 1'b1;
        end
        if (disp_en_in) begin
          state      <= RD_CHAR;
          pixel_read <= 1'b1;
          pixel_addr <= {ma[AW-2:0], 1'b0};
          ra_q       <= ra;
        end else begin
          state      <= IDLE;
          pixel_read <= 1'b0;
        end
      end else begin
        if (pix_ce) begin
          shreg <= {shreg[CELL_W-2:0], 1'b0};
        end
        case (state)
          RD_CHAR: begin
            state      <= RD_ATTR;
            pixel_addr <= {pixel_addr[AW-1:1], 1'b1};
          end
          RD_ATTR: begin
            state      <= RD_FONT;
            pixel_read <= 1'b0;
            char_q     <= pixel_data;
          end
          RD_FONT: begin
            state  <= READY;
            attr_q <= pixel_data;
            font_q <= font_data;
          end
          default: begin
          end
        endcase
      end

      if (pix_ce) begin
        rgbi <= disp_en_out
              ? cell_pixel(shreg[CELL_W-1], attr_out, blink_en, blink_cnt[BLINK_CHAR_BIT])
              : 4'h0;
      end
    end
  end

endmodule

// File: tb/tb_cga_text_fetch.sv
// Bench for cga_text_fetch: VRAM and font ROM models, table of cells, blink,
// underrun and reset sequences. Define CGA_CURSOR_EN to also cover the cursor.
module tb_cga_text_fetch;
  import cga_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_ce = 1'b0;
  logic        char_start = 1'b0;
  logic        disp_en_in = 1'b0;
  logic [13:0] ma = '0;
  logic [2:0]  ra = '0;
  logic        vsync_pulse = 1'b0;
  logic        blink_en = 1'b0;
`ifdef CGA_CURSOR_EN
  logic        cursor_in = 1'b0;
`endif
  logic [14:0] pixel_addr;
  logic        pixel_read;
  logic [7:0]  pixel_data = '0;
  logic [10:0] font_addr;
  logic [7:0]  font_data = '0;
  logic [3:0]  rgbi;
  logic        disp_en_out;
  logic        underrun;
  fetch_dbg_t  dbg;

  logic [7:0]  vram [0:32767];
  logic [7:0]  rom  [0:2047];
  logic [4:0]  exp_q[$];
  logic [4:0]  bcnt = '0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [13:0] ma;
    logic [2:0]  ra;
    logic        de;
    logic [7:0]  chr;
    logic [7:0]  attr;
    logic [7:0]  font;
    logic        be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  cga_text_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .pix_ce      (pix_ce),
    .char_start  (char_start),
    .disp_en_in  (disp_en_in),
    .ma          (ma),
    .ra          (ra),
    .vsync_pulse (vsync_pulse),
    .blink_en    (blink_en),
`ifdef CGA_CURSOR_EN
    .cursor_in   (cursor_in),
`endif
    .pixel_addr  (pixel_addr),
    .pixel_read  (pixel_read),
    .pixel_data  (pixel_data),
    .font_addr   (font_addr),
    .font_data   (font_data),
    .rgbi        (rgbi),
    .disp_en_out (disp_en_out),
    .underrun    (underrun),
    .dbg         (dbg)
  );

  // clock / memories
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pixel_read) pixel_data <= vram[pixel_addr];
    font_data <= rom[font_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pixel_read"}, 32'(pixel_read), 32'd0);
    check({tag, "_pixel_addr"}, 32'(pixel_addr), 32'd0);
    check({tag, "_font_addr"}, 32'(font_addr), 32'd0);
    check({tag, "_rgbi"}, 32'(rgbi), 32'd0);
    check({tag, "_disp_en_out"}, 32'(disp_en_out), 32'd0);
    check({tag, "_underrun"}, 32'(underrun), 32'd0);
    check({tag, "_state"}, 32'(dbg.state), 32'(IDLE));
    check({tag, "_blink_cnt"}, 32'(dbg.blink_cnt), 32'd0);
  endtask

  // Starts a cell (caller is at a negedge) and shows npix pixels of the previously
  // fetched cell, whose expected colours (MSB nibble first) are exp_pix.
  task automatic run_cell(input logic [13:0] c_ma, input logic [2:0] c_ra, input logic c_de,
                          input logic be, input logic [31:0] exp_pix, input logic exp_de,
                          input int npix);
    logic [4:0] item;
    logic [7:0] chr;
    chr = vram[{c_ma, 1'b0}];
    char_start = 1'b1;
    disp_en_in = c_de;
    ma = c_ma;
    ra = c_ra;
    blink_en = be;
    for (int k = 0; k < npix; k++) exp_q.push_back({exp_de, exp_pix[31-4*k -: 4]});
    @(negedge clk);
    char_start = 1'b0;
    pix_ce = 1'b1;
    for (int k = 0; k < npix; k++) begin
      if (!c_de) begin
        check("no_fetch_read", 32'(pixel_read), 32'd0);
        check("no_fetch_state", 32'(dbg.state), 32'(IDLE));
      end else begin
        case (k)
          0: begin
            check("rd_char_read", 32'(pixel_read), 32'd1);
            check("rd_char_addr", 32'(pixel_addr), 32'({c_ma, 1'b0}));
          end
          1: begin
            check("rd_attr_read", 32'(pixel_read), 32'd1);
            check("rd_attr_addr", 32'(pixel_addr), 32'({c_ma, 1'b1}));
            check("font_addr", 32'(font_addr), 32'({chr, c_ra}));
          end
          2: begin
            check("rd_font_read", 32'(pixel_read), 32'd0);
            check("rd_font_state", 32'(dbg.state), 32'(RD_FONT));
          end
          3: check("ready_state", 32'(dbg.state), 32'(READY));
          default: begin
          end
        endcase
      end
      @(negedge clk);
      item = exp_q.pop_front();
      check($sformatf("pixel%0d", k), 32'({disp_en_out, rgbi}), 32'(item));
    end
    pix_ce = 1'b0;
  endtask

  task automatic load_cell(input logic [13:0] c_ma, input logic [2:0] c_ra,
                           input logic [7:0] chr, input logic [7:0] attr, input logic [7:0] font);
    vram[{c_ma, 1'b0}] = chr;
    vram[{c_ma, 1'b1}] = attr;
    rom[{chr, c_ra}] = font;
  endtask

  task automatic pulse_vsync();
    vsync_pulse = 1'b1;
    @(negedge clk);
    vsync_pulse = 1'b0;
    bcnt = bcnt + 5'd1;
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [13:0] bma;
    logic [2:0]  bra;

    for (int i = 0; i < 32768; i++) vram[i] = 8'(i);
    for (int i = 0; i < 2048; i++) rom[i] = 8'(i) ^ 8'h5A;

    vecs[0] = '{14'h0123, 3'd2, 1'b1, 8'h41, 8'h1E, 8'h18, 1'b0, 32'h111EE111};
    vecs[1] = '{14'h0005, 3'd0, 1'b1, 8'h00, 8'h07, 8'hFF, 1'b0, 32'h77777777};
    vecs[2] = '{14'h0010, 3'd6, 1'b0, 8'h22, 8'h33, 8'h44, 1'b0, 32'h00000000};
    vecs[3] = '{14'h3FFF, 3'd1, 1'b1, 8'hAB, 8'h4A, 8'hA5, 1'b0, 32'hA4A44A4A};
    vecs[4] = '{14'h0200, 3'd7, 1'b1, 8'hFF, 8'hF1, 8'h81, 1'b1, 32'h17777771};
    vecs[5] = '{14'h00AA, 3'd5, 1'b1, 8'h5A, 8'h90, 8'hF0, 1'b0, 32'h00009999};

    // reset state
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // table of cells; each is displayed during the following cell
    for (int i = 0; i < 6; i++) begin
      load_cell(vecs[i].ma, vecs[i].ra, vecs[i].chr, vecs[i].attr, vecs[i].font);
      if (i == 0) run_cell(vecs[i].ma, vecs[i].ra, vecs[i].de, 1'b0, 32'h0, 1'b0, 8);
      else run_cell(vecs[i].ma, vecs[i].ra, vecs[i].de, vecs[i-1].be, vecs[i-1].exp, vecs[i-1].de, 8);
    end
    check("underrun_clean", 32'(underrun), 32'd0);

    // underrun: next boundary only 2 clk after the previous one
    load_cell(14'h0050, 3'd1, 8'h33, 8'h2C, 8'h3C);
    load_cell(14'h0060, 3'd3, 8'h44, 8'h5B, 8'hC3);
    run_cell(14'h0050, 3'd1, 1'b1, vecs[5].be, vecs[5].exp, 1'b1, 1);
    run_cell(14'h0060, 3'd3, 1'b1, 1'b0, 32'h00000000, 1'b1, 8);
    check("underrun_set", 32'(underrun), 32'd1);

    // blink: attr 0x8F, font 0xF0, random cell positions
    bma = 14'($urandom_range(14'h0400, 14'h07FF));
    bra = 3'($urandom_range(0, 7));
    load_cell(bma, bra, 8'h80, 8'h8F, 8'hF0);
    run_cell(bma, bra, 1'b1, 1'b0, 32'hBB5555BB, 1'b1, 8);
    for (int j = 0; j < 32; j++) begin
      bma = 14'($urandom_range(14'h0400, 14'h07FF));
      bra = 3'($urandom_range(0, 7));
      load_cell(bma, bra, 8'h80, 8'h8F, 8'hF0);
      run_cell(bma, bra, 1'b1, 1'b1, bcnt[4] ? 32'h00000000 : 32'hFFFF0000, 1'b1, 8);
      check("blink_cnt", 32'(dbg.blink_cnt), 32'(bcnt));
      pulse_vsync();
    end
    run_cell(bma, bra, 1'b1, 1'b0, 32'hFFFF8888, 1'b1, 8);
    run_cell(bma, bra, 1'b1, 1'b1, 32'hFFFF0000, 1'b1, 8);
    check("blink_wrap", 32'(dbg.blink_cnt), 32'd0);
    check("underrun_sticky", 32'(underrun), 32'd1);

    // asynchronous reset in the middle of RD_ATTR
    char_start = 1'b1;
    disp_en_in = 1'b1;
    ma = 14'h0321;
    ra = 3'd0;
    @(negedge clk);
    char_start = 1'b0;
    @(negedge clk);
    check("pre_reset_state", 32'(dbg.state), 32'(RD_ATTR));
    reset = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    bcnt = '0;
    run_cell(vecs[1].ma, vecs[1].ra, 1'b1, 1'b0, 32'h0, 1'b0, 8);
    run_cell(vecs[2].ma, vecs[2].ra, 1'b0, 1'b0, vecs[1].exp, 1'b1, 8);
    run_cell(vecs[2].ma, vecs[2].ra, 1'b0, 1'b0, 32'h0, 1'b0, 8);

`ifdef CGA_CURSOR_EN
    for (int j = 0; j < 8; j++) pulse_vsync();
    load_cell(14'h0700, 3'd0, 8'h90, 8'h07, 8'h00);
    cursor_in = 1'b1;
    run_cell(14'h0700, 3'd0, 1'b1, 1'b0, 32'h0, 1'b0, 8);
    cursor_in = 1'b0;
    run_cell(vecs[2].ma, vecs[2].ra, 1'b0, 1'b0, 32'h77777777, 1'b1, 8);
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
